// File: rtl/slot_pkg.sv
// Shared types and constants for the slot machine payout block.
// Optional feature macro: SLOT_JACKPOT_EN (triple 7 pays PAY_JACKPOT).
package slot_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_ADD  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [15:0] CREDIT_INIT = 16'h5000;
  localparam logic [15:0] BET         = 16'h0010;
  localparam logic [15:0] PAY_TRIPLE  = 16'h0100;
  localparam logic [15:0] PAY_PAIR    = 16'h0020;
  localparam logic [15:0] PAY_JACKPOT = 16'h0500;
  localparam logic [15:0] CREDIT_SAT  = 16'h9999;
  localparam bcd_t        BCD_MAX     = 4'd9;

  // Stake is 0010: digit 0 is untouched, borrow ripples through digits 1-3.
  function automatic logic [15:0] bcd_sub_bet(input logic [15:0] c);
    logic [15:0] r;
    logic        borrow;
    r      = c;
    borrow = 1'b1;
    for (int i = 1; i < 4; i++) begin
      if (borrow) begin
        if (r[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = 4'd9;
          borrow      = 1'b1;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end else begin
        borrow = 1'b0;
      end
    end
    return r;
  endfunction

  // A BCD balance is at least 0010 exactly when some digit above digit 0 is non-zero.
  function automatic logic bcd_ge_bet(input logic [15:0] c);
    return (c[15:4] != 12'h000);
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single decimal digit adder with carry in/out; sums above 9 are corrected by +6.
module bcd_digit_add
  import slot_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] raw_s;

  // Binary add followed by decimal correction.
  always_comb begin
    raw_s = {1'b0, a} + {1'b0, b} + {4'd0, cin};
    if (raw_s > {1'b0, BCD_MAX}) begin
      sum  = raw_s[3:0] + 4'd6;
      cout = 1'b1;
    end else begin
      sum  = raw_s[3:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/slot_payout.sv
// Slot machine payout controller: classifies a spin, adds the payout to a
// 4-digit BCD credit one digit per cycle, and handles $10 bets while idle.
// Optional feature macro: SLOT_JACKPOT_EN (triple 7 pays 0500 instead of 0100).
module slot_payout
  import slot_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        reel_valid,
  input  logic [3:0]  reel0,
  input  logic [3:0]  reel1,
  input  logic [3:0]  reel2,
  input  logic        bet_valid,
  output logic        ready,
  output logic [15:0] credit,
  output logic [15:0] win_amount,
  output logic        win_valid,
  output logic        bet_err,
  output logic        overflow
);

  state_t      state_r, state_s;
  bcd_t        reel0_r, reel1_r, reel2_r;
  bcd_t        reel0_s, reel1_s, reel2_s;
  logic [15:0] credit_r, credit_s;
  logic [15:0] win_r, win_s;
  logic [15:0] pay_s;
  logic [1:0]  idx_r, idx_s;
  logic        carry_r, carry_s;
  logic        overflow_r, overflow_s;
  logic        bet_err_r, bet_err_s;
  logic        win_valid_r, win_valid_s;
  logic        ready_r, ready_s;
  bcd_t        add_a_s, add_b_s, add_sum_s;
  logic        add_cout_s;
  logic        eq01_s, eq12_s, eq02_s;

  // The one digit adder, reused for each of the four ADD cycles.
  bcd_digit_add u_add (
    .a    (add_a_s),
    .b    (add_b_s),
    .cin  (carry_r),
    .sum  (add_sum_s),
    .cout (add_cout_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (reel_valid) begin
          state_s = ST_EVAL;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_EVAL: state_s = ST_ADD;
      ST_ADD: begin
        if (idx_r == 2'd3) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_ADD;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Spin classification; digits above 9 never count as a match.
  always_comb begin
    eq01_s = (reel0_r == reel1_r) && (reel0_r <= BCD_MAX);
    eq12_s = (reel1_r == reel2_r) && (reel1_r <= BCD_MAX);
    eq02_s = (reel0_r == reel2_r) && (reel0_r <= BCD_MAX);
    if (eq01_s && eq12_s) begin
`ifdef SLOT_JACKPOT_EN
      if (reel0_r == 4'd7) begin
        pay_s = PAY_JACKPOT;
      end else begin
        pay_s = PAY_TRIPLE;
      end
`else
      pay_s = PAY_TRIPLE;
`endif
    end else if (eq01_s || eq12_s || eq02_s) begin
      pay_s = PAY_PAIR;
    end else begin
      pay_s = 16'h0000;
    end
  end

  // Select the credit/payout digit pair for the current ADD step.
  always_comb begin
    case (idx_r)
      2'd0:    begin add_a_s = credit_r[3:0];   add_b_s = win_r[3:0];   end
      2'd1:    begin add_a_s = credit_r[7:4];   add_b_s = win_r[7:4];   end
      2'd2:    begin add_a_s = credit_r[11:8];  add_b_s = win_r[11:8];  end
      2'd3:    begin add_a_s = credit_r[15:12]; add_b_s = win_r[15:12]; end
      default: begin add_a_s = credit_r[3:0];   add_b_s = win_r[3:0];   end
    endcase
  end

  // FSM output and datapath next-value logic.
  always_comb begin
    reel0_s    = reel0_r;
    reel1_s    = reel1_r;
    reel2_s    = reel2_r;
    credit_s   = credit_r;
    win_s      = win_r;
    idx_s      = idx_r;
    carry_s    = carry_r;
    overflow_s = overflow_r;
    bet_err_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (reel_valid) begin
          reel0_s   = reel0;
          reel1_s   = reel1;
          reel2_s   = reel2;
          // A simultaneous bet loses to the spin and is reported as refused.
          bet_err_s = bet_valid;
        end else if (bet_valid) begin
          if (bcd_ge_bet(credit_r)) begin
            credit_s = bcd_sub_bet(credit_r);
          end else begin
            bet_err_s = 1'b1;
          end
        end else begin
          bet_err_s = 1'b0;
        end
      end
      ST_EVAL: begin
        win_s     = pay_s;
        idx_s     = 2'd0;
        carry_s   = 1'b0;
        bet_err_s = bet_valid;
      end
      ST_ADD: begin
        bet_err_s = bet_valid;
        idx_s     = idx_r + 2'd1;
        carry_s   = add_cout_s;
        case (idx_r)
          2'd0: credit_s[3:0]  = add_sum_s;
          2'd1: credit_s[7:4]  = add_sum_s;
          2'd2: credit_s[11:8] = add_sum_s;
          2'd3: begin
            if (add_cout_s) begin
              credit_s   = CREDIT_SAT;
              overflow_s = 1'b1;
            end else begin
              credit_s[15:12] = add_sum_s;
            end
          end
          default: credit_s = credit_r;
        endcase
      end
      ST_DONE: begin
        bet_err_s = bet_valid;
      end
      default: begin
        bet_err_s = 1'b0;
      end
    endcase
    win_valid_s = (state_s == ST_DONE);
    ready_s     = (state_s == ST_IDLE);
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reel0_r     <= 4'd0;
      reel1_r     <= 4'd0;
      reel2_r     <= 4'd0;
      credit_r    <= CREDIT_INIT;
      win_r       <= 16'h0000;
      idx_r       <= 2'd0;
      carry_r     <= 1'b0;
      overflow_r  <= 1'b0;
      bet_err_r   <= 1'b0;
      win_valid_r <= 1'b0;
      ready_r     <= 1'b1;
    end else begin
      reel0_r     <= reel0_s;
      reel1_r     <= reel1_s;
      reel2_r     <= reel2_s;
      credit_r    <= credit_s;
      win_r       <= win_s;
      idx_r       <= idx_s;
      carry_r     <= carry_s;
      overflow_r  <= overflow_s;
      bet_err_r   <= bet_err_s;
      win_valid_r <= win_valid_s;
      ready_r     <= ready_s;
    end
  end

  assign ready      = ready_r;
  assign credit     = credit_r;
  assign win_amount = win_r;
  assign win_valid  = win_valid_r;
  assign bet_err    = bet_err_r;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_slot_payout.sv
// Directed testbench for slot_payout with hand-computed expectations.
// Honours SLOT_JACKPOT_EN for the triple-7 payout.
module tb_slot_payout;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reel_valid = 1'b0;
  logic        bet_valid = 1'b0;
  logic [3:0]  reel0 = 4'd0, reel1 = 4'd0, reel2 = 4'd0;
  logic        ready, win_valid, bet_err, overflow;
  logic [15:0] credit, win_amount;

  int n_checks = 0;
  int n_fail   = 0;
  int wv_seen;

  slot_payout dut (
    .clk        (clk),
    .reset      (reset),
    .reel_valid (reel_valid),
    .reel0      (reel0),
    .reel1      (reel1),
    .reel2      (reel2),
    .bet_valid  (bet_valid),
    .ready      (ready),
    .credit     (credit),
    .win_amount (win_amount),
    .win_valid  (win_valid),
    .bet_err    (bet_err),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    reel_valid = 1'b0;
    bet_valid  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic bet();
    bet_valid = 1'b1;
    tick();
    bet_valid = 1'b0;
  endtask

  // Edge 0 samples reel_valid; DONE follows edge 5, IDLE follows edge 6.
  task automatic spin(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input bit chk);
    reel0 = a; reel1 = b; reel2 = c;
    reel_valid = 1'b1;
    tick();
    reel_valid = 1'b0;
    if (chk) check_eq("ready_busy", {15'd0, ready}, 16'd0);
    for (int k = 1; k < 5; k++) begin
      tick();
      if (chk) check_eq("wv_early", {15'd0, win_valid}, 16'd0);
    end
    tick();
    if (chk) check_eq("wv_at_n6", {15'd0, win_valid}, 16'd1);
    tick();
    if (chk) begin
      check_eq("ready_n7", {15'd0, ready}, 16'd1);
      check_eq("wv_off_n7", {15'd0, win_valid}, 16'd0);
    end
  endtask

  initial begin
    do_reset();
    check_eq("rst_ready", {15'd0, ready}, 16'd1);
    check_eq("rst_credit", credit, 16'h5000);
    check_eq("rst_win", win_amount, 16'h0000);
    check_eq("rst_wv", {15'd0, win_valid}, 16'd0);
    check_eq("rst_berr", {15'd0, bet_err}, 16'd0);
    check_eq("rst_ovf", {15'd0, overflow}, 16'd0);

    // Triple and pair payouts.
    spin(4'd3, 4'd3, 4'd3, 1'b1);
    check_eq("triple_win", win_amount, 16'h0100);
    check_eq("triple_credit", credit, 16'h5100);

    do_reset();
    spin(4'd2, 4'd5, 4'd2, 1'b1);
    check_eq("pair_win", win_amount, 16'h0020);
    check_eq("pair_credit", credit, 16'h5020);
    spin(4'd1, 4'd2, 4'd3, 1'b1);
    check_eq("none_win", win_amount, 16'h0000);
    check_eq("none_credit", credit, 16'h5020);
    spin(4'd12, 4'd12, 4'd12, 1'b0);
    check_eq("nonbcd_win", win_amount, 16'h0000);
    spin(4'd4, 4'd4, 4'd11, 1'b0);
    check_eq("pair_nonbcd_win", win_amount, 16'h0020);
    check_eq("pair_nonbcd_credit", credit, 16'h5040);
    tick();
    tick();
    check_eq("win_hold", win_amount, 16'h0020);

    // Triple 7.
    do_reset();
    spin(4'd7, 4'd7, 4'd7, 1'b0);
`ifdef SLOT_JACKPOT_EN
    check_eq("seven_win", win_amount, 16'h0500);
    check_eq("seven_credit", credit, 16'h5500);
`else
    check_eq("seven_win", win_amount, 16'h0100);
    check_eq("seven_credit", credit, 16'h5100);
`endif

    // Climb to 9950, then saturate.
    do_reset();
    for (int i = 0; i < 49; i++) spin(4'd1, 4'd1, 4'd1, 1'b0);
    for (int i = 0; i < 3; i++) spin(4'd6, 4'd6, 4'd0, 1'b0);
    bet();
    check_eq("pre_ovf_credit", credit, 16'h9950);
    check_eq("pre_ovf_flag", {15'd0, overflow}, 16'd0);
    spin(4'd3, 4'd3, 4'd3, 1'b0);
    check_eq("ovf_credit", credit, 16'h9999);
    check_eq("ovf_flag", {15'd0, overflow}, 16'd1);
    bet();
    check_eq("ovf_bet_credit", credit, 16'h9989);
    check_eq("ovf_sticky", {15'd0, overflow}, 16'd1);
    for (int i = 0; i < 998; i++) bet();
    check_eq("low_credit", credit, 16'h0009);
    bet();
    check_eq("low_bet_err", {15'd0, bet_err}, 16'd1);
    check_eq("low_bet_credit", credit, 16'h0009);
    tick();
    check_eq("low_bet_err_pulse", {15'd0, bet_err}, 16'd0);

    // Bets with borrow and the 0010 boundary.
    do_reset();
    for (int i = 0; i < 400; i++) bet();
    check_eq("credit_1000", credit, 16'h1000);
    bet();
    check_eq("bet_borrow", credit, 16'h0990);
    check_eq("bet_ok_err", {15'd0, bet_err}, 16'd0);
    check_eq("bet_ready", {15'd0, ready}, 16'd1);
    for (int i = 0; i < 98; i++) bet();
    check_eq("credit_0010", credit, 16'h0010);
    bet();
    check_eq("bet_to_zero", credit, 16'h0000);
    check_eq("bet_zero_err", {15'd0, bet_err}, 16'd0);
    bet();
    check_eq("bet_empty_err", {15'd0, bet_err}, 16'd1);
    check_eq("bet_empty_credit", credit, 16'h0000);

    // Bet during ADD is ignored and refused.
    do_reset();
    reel0 = 4'd2; reel1 = 4'd5; reel2 = 4'd2;
    reel_valid = 1'b1;
    tick();
    reel_valid = 1'b0;
    tick();
    bet_valid = 1'b1;
    tick();
    bet_valid = 1'b0;
    check_eq("busy_bet_err", {15'd0, bet_err}, 16'd1);
    for (int i = 0; i < 4; i++) tick();
    check_eq("busy_bet_credit", credit, 16'h5020);

    // Spin and bet together: spin wins.
    reel0 = 4'd2; reel1 = 4'd2; reel2 = 4'd2;
    reel_valid = 1'b1;
    bet_valid  = 1'b1;
    tick();
    reel_valid = 1'b0;
    bet_valid  = 1'b0;
    check_eq("both_bet_err", {15'd0, bet_err}, 16'd1);
    for (int i = 0; i < 6; i++) tick();
    check_eq("both_win", win_amount, 16'h0100);
    check_eq("both_credit", credit, 16'h5120);

    // Reset in the middle of ADD.
    reel0 = 4'd5; reel1 = 4'd5; reel2 = 4'd5;
    reel_valid = 1'b1;
    tick();
    reel_valid = 1'b0;
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    check_eq("midrst_credit", credit, 16'h5000);
    check_eq("midrst_win", win_amount, 16'h0000);
    @(posedge clk);
    #1;
    reset = 1'b0;
    wv_seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (win_valid) wv_seen++;
    end
    check_eq("midrst_no_wv", wv_seen[15:0], 16'd0);
    check_eq("midrst_ready", {15'd0, ready}, 16'd1);
    check_eq("midrst_credit_after", credit, 16'h5000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/slot_payout.md
SLOT_PAYOUT -- requirements
Module: slot_payout

Interface
REQ-001 The block SHALL be clocked by a single clock, clk; reset is asynchronous and active-high.
REQ-002 Port clk  input  1  system clock; all state changes on rising edge.
REQ-003 Port reset  input  1  asynchronous, active-high; clears all state.
REQ-004 Port reel_valid  input  1  one-cycle pulse: reels stopped, reel digits stable.
REQ-005 Port reel0, reel1, reel2  input  4 each  BCD reel digits 0-9; values 10-15 are treated as no-match.
REQ-006 Port bet_valid  input  1  one-cycle pulse: deduct a $10 stake from credit.
REQ-007 Port ready  output  1  high when in IDLE and able to accept reel_valid.
REQ-008 Port credit  output  16  4-digit BCD balance, digit 3 in [15:12].
REQ-009 Port win_amount  output  16  4-digit BCD payout of the last evaluated spin.
REQ-010 Port win_valid  output  1  one-cycle pulse when credit includes the new payout.
REQ-011 Port bet_err  output  1  one-cycle pulse when a bet is refused.
REQ-012 Port overflow  output  1  sticky flag: a credit addition saturated.

Function
REQ-013 The FSM SHALL have states IDLE, EVAL, ADD and DONE; ready SHALL be high only in IDLE.
REQ-014 IDLE: on reel_valid, the block SHALL latch the reel digits and go to EVAL; reel_valid outside IDLE SHALL be ignored.
REQ-015 EVAL (1 cycle): the block SHALL classify the spin; all three equal = 0100; exactly two equal = 0020; otherwise 0000. It SHALL latch the result into win_amount and go to ADD.
REQ-016 ADD (4 cycles): the block SHALL add win_amount to credit one BCD digit per cycle, digits 0 to 3, with decimal carry; each digit sum above 9 SHALL have 6 added and carry 1 out.
REQ-017 If a carry leaves digit 3, credit SHALL become 9999 and overflow SHALL be set.
REQ-018 DONE (1 cycle): win_valid SHALL be high and the FSM SHALL return to IDLE.
REQ-019 Latency: for reel_valid sampled at edge N, win_valid SHALL be high in cycle N+6, and ready SHALL be high again at N+7.
REQ-020 Bet in IDLE with credit >= 0010: the block SHALL subtract 0010 in BCD with borrow through digits 1-3, update credit at the next edge, and leave ready high.
REQ-021 Bet in IDLE with credit < 0010: credit SHALL be unchanged and bet_err SHALL pulse for 1 cycle.
REQ-022 bet_valid outside IDLE SHALL be ignored and SHALL pulse bet_err.
REQ-023 If reel_valid and bet_valid arrive together in IDLE, reel_valid SHALL win; the bet SHALL be dropped and bet_err SHALL pulse.
REQ-024 win_amount SHALL hold its value until the next EVAL.

Reset
REQ-025 On reset: state = IDLE, credit = 5000 (BCD), win_amount = 0000, and win_valid, bet_err and overflow = 0.
REQ-026 When reset is asserted mid-spin (EVAL, ADD or DONE), the spin SHALL be aborted with no win_valid, and credit SHALL take its reset value immediately.

Configuration
REQ-027 With macro SLOT_JACKPOT_EN defined, a triple 7 SHALL pay 0500; all other payouts are unchanged.
REQ-028 Without SLOT_JACKPOT_EN, a triple 7 SHALL pay 0100 like any other triple, and no jackpot logic SHALL be synthesized.

Structure
REQ-029 Package slot_pkg SHALL hold:
- the BCD digit typedef (4 bits);
- the FSM state enum;
- constants CREDIT_INIT = 5000, BET = 0010, PAY_TRIPLE = 0100, PAY_PAIR = 0020, PAY_JACKPOT = 0500.
REQ-030 The single-digit decimal adder (digit a, digit b, carry in -> digit sum, carry out) SHALL be a sub-module, bcd_digit_add, instantiated once and reused serially in ADD.

Verification
REQ-031 Reset, then reels 3,3,3 -> win_amount = 0100, credit = 5100, win_valid exactly at N+6.
REQ-032 Reels 2,5,2 -> win_amount = 0020, credit 5000 -> 5020; reels 1,2,3 -> win_amount = 0000, credit unchanged, win_valid still pulses.
REQ-033 Reels 7,7,7 -> 0500 with SLOT_JACKPOT_EN and 0100 without it; credit 9950 plus 0100 -> 9999 with overflow = 1.
REQ-034 Bets:
- credit 1000, bet -> 0990;
- credit 0009, bet -> credit unchanged, bet_err pulses;
- bet during ADD -> bet ignored, bet_err pulses.
REQ-035 reel_valid and bet_valid in the same IDLE cycle -> spin processed, bet dropped, bet_err = 1; reset asserted during ADD -> credit = 5000, no win_valid, ready = 1 after release.
